multiplicador_cadena: RTL and testbench

- Parametrised sequential shift-add multiplier. It forms the product of N_OPER unsigned operands using one shared add/shift datapath.
- It replaces the practice of chaining several fixed-width multiplicador instances. It uses the same valid_data/ret_ack request handshake and Done_Flag/ack result handshake.
- Optional zero-skip mode returns a zero product early.

---
 rtl/multiplicador_cadena.sv | 150 +++++++++++++++
 tb/tb_multiplicador_cadena.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_cadena.sv
// Chained shift-add multiplier: product of N_OPER unsigned operands through
// one shared add/shift datapath, one multiplier bit per clock.
module multiplicador_cadena #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned N_OPER    = 3,
    parameter int unsigned ZERO_SKIP = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_OPER*WIDTH-1:0]   operandos,
    input  logic                      valid_data,
    output logic                      ret_ack,
    output logic                      Done_Flag,
    input  logic                      ack,
    output logic [N_OPER*WIDTH-1:0]   producto
);

    localparam int unsigned PW = N_OPER * WIDTH;
    localparam int unsigned SW = $clog2(N_OPER);
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [PW-1:0]   ops_q, ops_n;
    logic [PW-1:0]   acc_q, acc_n;
    logic [PW-1:0]   partial_q, partial_n;
    logic [SW-1:0]   stage_q, stage_n;
    logic [BW-1:0]   bit_q, bit_n;
    logic [PW-1:0]   producto_n;
    logic            done_n;
    logic            ret_ack_n;

    logic [WIDTH-1:0] cur_op;
    logic             any_zero;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    sum;

    // Select the operand currently acting as multiplier
    always_comb begin
        cur_op = '0;
        for (int k = 0; k < int'(N_OPER); k++) begin
            if (stage_q == SW'(k)) cur_op = ops_q[k*WIDTH +: WIDTH];
        end
    end

    // Detect a zero operand on the incoming request
    always_comb begin
        any_zero = 1'b0;
        for (int k = 0; k < int'(N_OPER); k++) begin
            if (operandos[k*WIDTH +: WIDTH] == '0) any_zero = 1'b1;
        end
    end

    // One shift-add step of the current stage
    always_comb begin
        addend = cur_op[bit_q] ? (acc_q << bit_q) : '0;
        sum    = partial_q + addend;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n    = state_q;
        ops_n      = ops_q;
        acc_n      = acc_q;
        partial_n  = partial_q;
        stage_n    = stage_q;
        bit_n      = bit_q;
        producto_n = producto;
        done_n     = Done_Flag;
        ret_ack_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_data) begin
                    ops_n     = operandos;
                    acc_n     = PW'(operandos[WIDTH-1:0]);
                    partial_n = '0;
                    stage_n   = SW'(1);
                    bit_n     = '0;
                    ret_ack_n = 1'b1;
                    if ((ZERO_SKIP != 0) && any_zero) begin
                        producto_n = '0;
                        done_n     = 1'b1;
                        state_n    = DONE;
                    end else begin
                        state_n    = MUL;
                    end
                end
            end
            MUL: begin
                if (bit_q == BW'(WIDTH - 1)) begin
                    acc_n     = sum;
                    partial_n = '0;
                    bit_n     = '0;
                    if (stage_q == SW'(N_OPER - 1)) begin
                        producto_n = sum;
                        done_n     = 1'b1;
                        state_n    = DONE;
                    end else begin
                        stage_n = stage_q + SW'(1);
                    end
                end else begin
                    partial_n = sum;
                    bit_n     = bit_q + BW'(1);
                end
            end
            DONE: begin
                if (ack) begin
                    done_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                done_n  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ops_q     <= '0;
            acc_q     <= '0;
            partial_q <= '0;
            stage_q   <= '0;
            bit_q     <= '0;
            producto  <= '0;
            Done_Flag <= 1'b0;
            ret_ack   <= 1'b0;
        end else begin
            state_q   <= state_n;
            ops_q     <= ops_n;
            acc_q     <= acc_n;
            partial_q <= partial_n;
            stage_q   <= stage_n;
            bit_q     <= bit_n;
            producto  <= producto_n;
            Done_Flag <= done_n;
            ret_ack   <= ret_ack_n;
        end
    end

endmodule

// File: tb/tb_multiplicador_cadena.sv
// Bench for multiplicador_cadena: three instances (3 operands with zero-skip,
// 3 operands without zero-skip, 2 operands) checked against plain arithmetic.
module tb_multiplicador_cadena;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] op_v [3];
    logic        valid_v [3];
    logic        ack_v [3];

    logic        ret0, ret1, ret2;
    logic        done0_s, done1_s, done2_s;
    logic [95:0] prod0, prod1;
    logic [63:0] prod2;

    int          tests = 0;
    int          fails = 0;
    logic [95:0] exp_prod;
    int          exp_lat;
    logic        done_at_capture;

    always #5 clk = ~clk;

    multiplicador_cadena #(.WIDTH(32), .N_OPER(3), .ZERO_SKIP(1)) dut0 (
        .clk(clk), .reset(reset), .operandos(op_v[0]), .valid_data(valid_v[0]),
        .ret_ack(ret0), .Done_Flag(done0_s), .ack(ack_v[0]), .producto(prod0));

    multiplicador_cadena #(.WIDTH(32), .N_OPER(3), .ZERO_SKIP(0)) dut1 (
        .clk(clk), .reset(reset), .operandos(op_v[1]), .valid_data(valid_v[1]),
        .ret_ack(ret1), .Done_Flag(done1_s), .ack(ack_v[1]), .producto(prod1));

    multiplicador_cadena #(.WIDTH(32), .N_OPER(2), .ZERO_SKIP(1)) dut2 (
        .clk(clk), .reset(reset), .operandos(op_v[2][63:0]), .valid_data(valid_v[2]),
        .ret_ack(ret2), .Done_Flag(done2_s), .ack(ack_v[2]), .producto(prod2));

    function automatic logic get_ret(input int sel);
        return (sel == 0) ? ret0 : (sel == 1) ? ret1 : ret2;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done0_s : (sel == 1) ? done1_s : done2_s;
    endfunction

    function automatic logic [95:0] get_prod(input int sel);
        return (sel == 0) ? prod0 : (sel == 1) ? prod1 : {32'h0, prod2};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: exact product and expected completion latency in edges after capture
    task automatic set_req(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
        @(negedge clk);
        if (sel == 2) begin
            op_v[2]  = {32'h0, b, a};
            exp_prod = 96'(a) * 96'(b);
            exp_lat  = 32;
            if (a == 0 || b == 0) exp_lat = 0;
        end else begin
            op_v[sel] = {c, b, a};
            exp_prod  = 96'(a) * 96'(b) * 96'(c);
            exp_lat   = 64;
            if (sel == 0 && (a == 0 || b == 0 || c == 0)) exp_lat = 0;
        end
        valid_v[sel] = 1'b1;
    endtask

    task automatic capture(input int sel);
        @(posedge clk); #1;
        check("ret_ack_capture", 96'(get_ret(sel)), 96'(1));
        valid_v[sel]    = 1'b0;
        done_at_capture = get_done(sel);
        @(posedge clk); #1;
        check("ret_ack_pulse_end", 96'(get_ret(sel)), 96'(0));
    endtask

    task automatic wait_done(input int sel);
        int n;
        n = 1;
        if (done_at_capture) n = 0;
        else begin
            while (!get_done(sel) && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("latency", 96'(n), 96'(exp_lat));
        check("producto", get_prod(sel), exp_prod);
    endtask

    task automatic hold(input int sel, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check("done_held", 96'(get_done(sel)), 96'(1));
            check("producto_held", get_prod(sel), exp_prod);
        end
    endtask

    task automatic release_ack(input int sel);
        #22;
        ack_v[sel] = 1'b1;
        @(posedge clk); #1;
        check("done_after_ack", 96'(get_done(sel)), 96'(0));
        check("producto_kept", get_prod(sel), exp_prod);
        ack_v[sel] = 1'b0;
    endtask

    task automatic full_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
        set_req(sel, a, b, c);
        capture(sel);
        wait_done(sel);
        release_ack(sel);
    endtask

    initial begin
        logic [31:0] ra, rb, rc;
        int          sel;
        logic        seen;

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op_v[i]    = '0;
            valid_v[i] = 1'b0;
            ack_v[i]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_producto", get_prod(i), 96'(0));
            check("reset_done", 96'(get_done(i)), 96'(0));
            check("reset_ret_ack", 96'(get_ret(i)), 96'(0));
        end
        @(negedge clk);
        reset = 1'b1;

        // Basic product and all-ones boundary
        full_op(0, 32'd10, 32'd10, 32'd10);
        check("ten_cubed", get_prod(0), 96'd1000);
        full_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("all_ones", get_prod(0), 96'hFFFF_FFFD_0000_0002_FFFF_FFFF);

        // Zero operand with and without zero-skip
        full_op(0, 32'd19347, 32'd0, 32'd10);
        full_op(1, 32'd19347, 32'd0, 32'd10);
        full_op(1, 32'd3, 32'd5, 32'd7);

        // Two-operand instance
        full_op(2, 32'd65535, 32'd65537, 32'd0);
        check("two_oper", get_prod(2), 96'd4294967295);

        // Reset in the middle of a multiplication
        set_req(0, 32'd123, 32'd456, 32'd789);
        capture(0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midreset_producto", get_prod(0), 96'(0));
        check("midreset_done", 96'(get_done(0)), 96'(0));
        check("midreset_ret_ack", 96'(get_ret(0)), 96'(0));
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (get_done(0)) seen = 1'b1;
        end
        check("no_done_after_reset", 96'(seen), 96'(0));
        full_op(0, 32'd2, 32'd3, 32'd4);
        check("after_reset", get_prod(0), 96'd24);

        // Long ack back-pressure, then ack together with a new request
        set_req(0, 32'd7, 32'd8, 32'd9);
        capture(0);
        wait_done(0);
        hold(0, 100);
        set_req(0, 32'd11, 32'd12, 32'd13);
        ack_v[0] = 1'b1;
        @(posedge clk); #1;
        check("no_accept_on_ack", 96'(get_ret(0)), 96'(0));
        check("done_dropped", 96'(get_done(0)), 96'(0));
        ack_v[0] = 1'b0;
        capture(0);
        wait_done(0);
        release_ack(0);
        check("second_result", get_prod(0), 96'd1716);

        // Randomized operands, occasionally zero
        for (int i = 0; i < 8; i++) begin
            sel = (i % 2 == 0) ? 0 : 2;
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'd0;
            if ($urandom_range(0, 2) == 0) ra = ra & 32'h0000_FFFF;
            full_op(sel, ra, rb, rc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
